// File: rtl/control_sequencer.sv
// control_sequencer: Moore fetch/execute control unit for a single-bus datapath.
// Walks IDLE -> T0..T2 (fetch) -> T3..T6 (execute) and drives the register
// load / bus-drive strobes plus the ALU function code for each step.
// Optional feature: define CTRL_MULDIV_EN to enable MUL/DIV (T5 LOin, T6 HIin);
// without it those opcodes halt the sequencer like any unlisted opcode.
module control_sequencer (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        Run,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        Zhiout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        LOin,
    output logic        HIin,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [3:0]  alu_op,
    output logic        Halted
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    // Execute-phase shape of an opcode; selects which T3..T6 recipe runs.
    typedef enum logic [1:0] {
        CL_BINARY, CL_UNARY, CL_MULDIV, CL_ILLEGAL
    } op_class_t;

    state_t    state;
    state_t    next_state;
    logic [4:0] op_q;
    logic [4:0] cur_op;
    op_class_t  op_class;
    state_t     done_state;

    // Only the opcode field steers control; the operand fields belong to the datapath.
    logic unused_ir_bits;
    assign unused_ir_bits = ^IR[26:0];

    function automatic op_class_t classify(input logic [4:0] op);
        if (op <= 5'd7)
            return CL_BINARY;
        else if (op == 5'd8 || op == 5'd9)
            return CL_UNARY;
`ifdef CTRL_MULDIV_EN
        else if (op == 5'd10 || op == 5'd11)
            return CL_MULDIV;
`endif
        else
            return CL_ILLEGAL;
    endfunction

    // The datapath IR is loaded at the end of T2, so T3 decodes the live IR
    // opcode and captures it; T4..T6 then run from the captured copy.
    assign cur_op     = (state == T3) ? IR[31:27] : op_q;
    assign op_class   = classify(cur_op);
    assign done_state = Run ? T0 : IDLE;

    // State register with asynchronous clear.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Opcode capture during T3 for the remaining execute steps.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear)
            op_q <= 5'd0;
        else if (state == T3)
            op_q <= IR[31:27];
    end

    // Next-state and Moore strobe decode.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        next_state = state;
        PCout      = 1'b0;
        Zhiout     = 1'b0;
        Zlowout    = 1'b0;
        MDRout     = 1'b0;
        MARin      = 1'b0;
        PCin       = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        LOin       = 1'b0;
        HIin       = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Grc        = 1'b0;
        Rin        = 1'b0;
        Rout       = 1'b0;
        alu_op     = 4'd0;
        Halted     = 1'b0;

        unique case (state)
            IDLE: begin
                if (Run)
                    next_state = T0;
            end
            T0: begin
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                Zin        = 1'b1;
                next_state = T1;
            end
            T1: begin
                Zlowout    = 1'b1;
                PCin       = 1'b1;
                Read       = 1'b1;
                MDRin      = 1'b1;
                next_state = T2;
            end
            T2: begin
                MDRout     = 1'b1;
                IRin       = 1'b1;
                next_state = T3;
            end
            T3: begin
                unique case (op_class)
                    CL_BINARY, CL_MULDIV: begin
                        Grb        = 1'b1;
                        Rout       = 1'b1;
                        Yin        = 1'b1;
                        next_state = T4;
                    end
                    CL_UNARY: begin
                        Grb        = 1'b1;
                        Rout       = 1'b1;
                        Zin        = 1'b1;
                        alu_op     = cur_op[3:0];
                        next_state = T4;
                    end
                    default: next_state = HALT;
                endcase
            end
            T4: begin
                if (op_class == CL_UNARY) begin
                    Zlowout    = 1'b1;
                    Gra        = 1'b1;
                    Rin        = 1'b1;
                    next_state = done_state;
                end else begin
                    Grc        = 1'b1;
                    Rout       = 1'b1;
                    Zin        = 1'b1;
                    alu_op     = cur_op[3:0];
                    next_state = T5;
                end
            end
            T5: begin
                Zlowout = 1'b1;
`ifdef CTRL_MULDIV_EN
                if (op_class == CL_MULDIV) begin
                    LOin       = 1'b1;
                    next_state = T6;
                end else begin
                    Gra        = 1'b1;
                    Rin        = 1'b1;
                    next_state = done_state;
                end
`else
                Gra        = 1'b1;
                Rin        = 1'b1;
                next_state = done_state;
`endif
            end
            T6: begin
`ifdef CTRL_MULDIV_EN
                Zhiout     = 1'b1;
                HIin       = 1'b1;
                next_state = done_state;
`else
                next_state = IDLE;
`endif
            end
            HALT: begin
                Halted = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: table-driven cycle vectors for control_sequencer,
// with expected strobe words queued per driven cycle and compared after the edge.
module tb_control_sequencer;

    logic        Clock;
    logic        Clear;
    logic        Run;
    logic [31:0] IR;
    logic PCout, Zhiout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin;
    logic LOin, HIin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, Halted;
    logic [3:0] alu_op;

    control_sequencer dut (
        .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR),
        .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .Zin(Zin), .LOin(LOin), .HIin(HIin), .IncPC(IncPC), .Read(Read),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .alu_op(alu_op), .Halted(Halted)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Strobe word layout, MSB first.
    localparam logic [23:0] B_PCOUT   = 24'h800000;
    localparam logic [23:0] B_ZHIOUT  = 24'h400000;
    localparam logic [23:0] B_ZLOWOUT = 24'h200000;
    localparam logic [23:0] B_MDROUT  = 24'h100000;
    localparam logic [23:0] B_MARIN   = 24'h080000;
    localparam logic [23:0] B_PCIN    = 24'h040000;
    localparam logic [23:0] B_MDRIN   = 24'h020000;
    localparam logic [23:0] B_IRIN    = 24'h010000;
    localparam logic [23:0] B_YIN     = 24'h008000;
    localparam logic [23:0] B_ZIN     = 24'h004000;
    localparam logic [23:0] B_LOIN    = 24'h002000;
    localparam logic [23:0] B_HIIN    = 24'h001000;
    localparam logic [23:0] B_INCPC   = 24'h000800;
    localparam logic [23:0] B_READ    = 24'h000400;
    localparam logic [23:0] B_GRA     = 24'h000200;
    localparam logic [23:0] B_GRB     = 24'h000100;
    localparam logic [23:0] B_GRC     = 24'h000080;
    localparam logic [23:0] B_RIN     = 24'h000040;
    localparam logic [23:0] B_ROUT    = 24'h000020;
    localparam logic [23:0] B_HALTED  = 24'h000001;

    localparam logic [23:0] E_IDLE = 24'h000000;
    localparam logic [23:0] E_T0   = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [23:0] E_T1   = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
    localparam logic [23:0] E_T2   = B_MDROUT | B_IRIN;
    localparam logic [23:0] E_B3   = B_GRB | B_ROUT | B_YIN;
    localparam logic [23:0] E_WB   = B_ZLOWOUT | B_GRA | B_RIN;
    localparam logic [23:0] E_LO   = B_ZLOWOUT | B_LOIN;
    localparam logic [23:0] E_HI   = B_ZHIOUT | B_HIIN;
    localparam logic [23:0] E_HALT = B_HALTED;

    function automatic logic [23:0] alu(input logic [3:0] op);
        return {19'd0, op, 1'b0};
    endfunction
    function automatic logic [23:0] e_b4(input logic [3:0] op);
        return B_GRC | B_ROUT | B_ZIN | alu(op);
    endfunction
    function automatic logic [23:0] e_u3(input logic [3:0] op);
        return B_GRB | B_ROUT | B_ZIN | alu(op);
    endfunction

    localparam logic [31:0] IR_ADD = 32'h00000000;
    localparam logic [31:0] IR_ROL = 32'h1A920000;
    localparam logic [31:0] IR_AND = 32'h30000000;
    localparam logic [31:0] IR_NEG = 32'h40000000;
    localparam logic [31:0] IR_NOT = 32'h48000000;
    localparam logic [31:0] IR_MUL = 32'h50000000;
    localparam logic [31:0] IR_BAD = 32'h78000000;
    localparam logic [31:0] IR_HLT = 32'hF8000000;

    logic [23:0] actual;
    logic [4:0]  bus_drives;
    assign actual     = {PCout, Zhiout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin,
                         Zin, LOin, HIin, IncPC, Read, Gra, Grb, Grc, Rin, Rout,
                         alu_op, Halted};
    assign bus_drives = {PCout, Zhiout, Zlowout, MDRout, Rout};

    typedef struct {
        string       name;
        logic        run;
        logic [31:0] ir;
        logic [23:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [23:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [23:0] exp);
        checks++;
        if (actual !== exp) begin
            errors++;
            $display("FAIL %s: got=%06h expected=%06h at %0t", name, actual, exp, $time);
        end
        checks++;
        if ($countones(bus_drives) > 1) begin
            errors++;
            $display("FAIL %s_bus: drives=%05b expected at most one", name, bus_drives);
        end
    endtask

    // Pop the oldest queued expectation and compare it with the current outputs.
    task automatic sb_pop();
        sb_t item;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got=empty expected=entry");
        end else begin
            checks--;
            item = sb.pop_front();
            check(item.name, item.exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected strobes, clock, compare.
    task automatic step(input string name, input logic run, input logic [31:0] ir,
                        input logic [23:0] exp);
        sb_t item;
        @(negedge Clock);
        Run = run;
        IR  = ir;
        item.name = name;
        item.exp  = exp;
        sb.push_back(item);
        @(posedge Clock);
        #1;
        sb_pop();
    endtask

    task automatic add(input string name, input logic run, input logic [31:0] ir,
                       input logic [23:0] exp);
        vec_t v;
        v.name = name;
        v.run  = run;
        v.ir   = ir;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    task automatic release_clear();
        @(negedge Clock);
        Clear = 1'b0;
        Run   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Clear = 1'b0;
        Run   = 1'b0;
        IR    = 32'h0;
        #2 Clear = 1'b1;
        #1 check("reset", E_IDLE);
        release_clear();

        // Run low after Clear: IDLE held with everything quiet.
        for (int i = 0; i < 10; i++)
            step($sformatf("idle_%0d", i), 1'b0, IR_ADD, E_IDLE);

        // ROL straight into AND, back-to-back with Run high.
        add("rol_t0", 1, IR_ROL, E_T0);    add("rol_t1", 1, IR_ROL, E_T1);
        add("rol_t2", 1, IR_ROL, E_T2);    add("rol_t3", 1, IR_ROL, E_B3);
        add("rol_t4", 1, IR_ROL, e_b4(4'd3));
        add("rol_t5", 1, IR_ROL, E_WB);
        add("and_t0", 1, IR_AND, E_T0);    add("and_t1", 1, IR_AND, E_T1);
        add("and_t2", 1, IR_AND, E_T2);    add("and_t3", 1, IR_AND, E_B3);
        add("and_t4", 1, IR_AND, e_b4(4'd6));
        add("and_t5", 1, IR_AND, E_WB);
        add("and_idle", 0, IR_AND, E_IDLE);
        // NOT with Run dropped right after T0: instruction still completes.
        add("not_t0", 1, IR_NOT, E_T0);    add("not_t1", 0, IR_NOT, E_T1);
        add("not_t2", 0, IR_NOT, E_T2);    add("not_t3", 0, IR_NOT, e_u3(4'd9));
        add("not_t4", 0, IR_NOT, E_WB);    add("not_idle", 0, IR_NOT, E_IDLE);
        // NEG with Run dropped during T3.
        add("neg_t0", 1, IR_NEG, E_T0);    add("neg_t1", 1, IR_NEG, E_T1);
        add("neg_t2", 1, IR_NEG, E_T2);    add("neg_t3", 1, IR_NEG, e_u3(4'd8));
        add("neg_t4", 0, IR_NEG, E_WB);    add("neg_idle", 0, IR_NEG, E_IDLE);
        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].name, vecs[i].run, vecs[i].ir, vecs[i].exp);

        // Unlisted opcode: quiet T3, then HALT that ignores Run until Clear.
        step("bad_t0", 1, IR_BAD, E_T0);
        step("bad_t1", 1, IR_BAD, E_T1);
        step("bad_t2", 1, IR_BAD, E_T2);
        step("bad_t3", 1, IR_BAD, E_IDLE);
        for (int i = 0; i < 5; i++)
            step($sformatf("bad_halt_%0d", i), 1, IR_BAD, E_HALT);
        #2 Clear = 1'b1;
        #1 check("bad_clear", E_IDLE);
        release_clear();
        step("bad_after", 0, IR_BAD, E_IDLE);

        // Explicit HALT opcode.
        step("hlt_t0", 1, IR_HLT, E_T0);
        step("hlt_t1", 1, IR_HLT, E_T1);
        step("hlt_t2", 1, IR_HLT, E_T2);
        step("hlt_t3", 1, IR_HLT, E_IDLE);
        step("hlt_halt", 1, IR_HLT, E_HALT);
        #2 Clear = 1'b1;
        #1 check("hlt_clear", E_IDLE);
        release_clear();

        // Clear in the middle of ADD T4 clears outputs without a clock edge.
        step("add_t0", 1, IR_ADD, E_T0);
        step("add_t1", 1, IR_ADD, E_T1);
        step("add_t2", 1, IR_ADD, E_T2);
        step("add_t3", 1, IR_ADD, E_B3);
        step("add_t4", 1, IR_ADD, e_b4(4'd0));
        #2 Clear = 1'b1;
        #1 check("add_async_clear", E_IDLE);
        step("add_clear_held", 1, IR_ADD, E_IDLE);
        release_clear();
        step("add_restart_t0", 1, IR_ADD, E_T0);

        // MUL continues from that T0.
        step("mul_t1", 1, IR_MUL, E_T1);
        step("mul_t2", 1, IR_MUL, E_T2);
`ifdef CTRL_MULDIV_EN
        step("mul_t3", 1, IR_MUL, E_B3);
        step("mul_t4", 1, IR_MUL, e_b4(4'd10));
        step("mul_t5", 1, IR_MUL, E_LO);
        step("mul_t6", 1, IR_MUL, E_HI);
        step("mul_idle", 0, IR_MUL, E_IDLE);
`else
        step("mul_t3", 1, IR_MUL, E_IDLE);
        step("mul_halt", 1, IR_MUL, E_HALT);
        #2 Clear = 1'b1;
        #1 check("mul_clear", E_IDLE);
        release_clear();
        step("mul_after", 0, IR_MUL, E_IDLE);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
